// File: rtl/ema_share_sched.sv
// Round-robin scheduler sharing one external EMA filter datapath across N_CH sample channels.
// Optional EMA_PRIME_EN: the first sample of each channel seeds its state directly.
module ema_share_sched #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 8,
  parameter int FLT_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            req_valid,
  input  logic [N_CH*DATA_W-1:0]     req_data,
  output logic [N_CH-1:0]            req_ready,
  output logic [DATA_W-1:0]          flt_curr_in,
  output logic [DATA_W-1:0]          flt_prev_out,
  input  logic [DATA_W-1:0]          flt_curr_out,
  output logic                       out_valid,
  output logic [$clog2(N_CH)-1:0]    out_ch,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(FLT_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   samp_q, samp_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic [CH_W-1:0]     och_q, och_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [N_CH];
  logic [DATA_W-1:0]   mem_d [N_CH];
  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   result;
`ifdef EMA_PRIME_EN
  logic [N_CH-1:0]     primed_q, primed_d;
`endif

  // Highest offset first so the nearest valid channel after rr_q wins last.
  always_comb begin
    int unsigned j;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % N_CH;
      if (req_valid[j]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(j);
      end
    end
  end

`ifdef EMA_PRIME_EN
  assign result = primed_q[ch_q] ? flt_curr_out : samp_q;
`else
  assign result = flt_curr_out;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    ch_d      = ch_q;
    samp_d    = samp_q;
    prev_d    = prev_q;
    odata_d   = odata_q;
    och_d     = och_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    req_ready = '0;
`ifdef EMA_PRIME_EN
    primed_d  = primed_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = ~reset;
          samp_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
          ch_d    = grant_idx;
          prev_d  = mem_q[grant_idx];
          rr_d    = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(FLT_LAT)) begin
          mem_d[ch_q] = result;
          odata_d     = result;
          och_d       = ch_q;
          state_d     = DONE;
`ifdef EMA_PRIME_EN
          primed_d[ch_q] = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      samp_q  <= '0;
      prev_q  <= '0;
      odata_q <= '0;
      och_q   <= '0;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      samp_q  <= samp_d;
      prev_q  <= prev_d;
      odata_q <= odata_d;
      och_q   <= och_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

`ifdef EMA_PRIME_EN
  always_ff @(posedge clk) begin
    if (reset) primed_q <= '0;
    else       primed_q <= primed_d;
  end
`endif

  // Operands come straight from registers loaded at grant, so they hold between passes.
  assign flt_curr_in  = samp_q;
  assign flt_prev_out = prev_q;
  assign out_valid    = (state_q == DONE) && !reset;
  assign out_ch       = out_valid ? och_q : '0;
  assign out_data     = odata_q;
  assign busy         = (state_q != IDLE);

endmodule
